// File: rtl/cache_bus_arbiter.sv
// Two-way arbiter sharing one line-burst bus port between the I$ and D$ bus interfaces.
// Define CACHE_ARB_ROUNDROBIN_EN for round-robin tie-break; default is fixed D$ priority.
module cache_bus_arbiter #(
    parameter int PA_BITS      = 34,
    parameter int LOGBWPL      = 3,
    parameter int BEATSPERLINE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         ICacheBusRW,
    input  logic [PA_BITS-1:0] ICacheBusAdr,
    input  logic [1:0]         DCacheBusRW,
    input  logic [PA_BITS-1:0] DCacheBusAdr,
    output logic               ICacheBusAck,
    output logic               DCacheBusAck,
    output logic [LOGBWPL-1:0] IBeatCount,
    output logic [LOGBWPL-1:0] DBeatCount,
    output logic               IGrant,
    output logic               DGrant,
    output logic [1:0]         BusRW,
    output logic [PA_BITS-1:0] BusAdr,
    input  logic               BeatDone
);

    typedef enum logic [1:0] {StIdle, StIBus, StDBus} state_t;

    state_t             state_q, state_d;
    logic [LOGBWPL-1:0] beat_q, beat_d;
    logic               i_req, d_req, tie_to_d, last_beat;

`ifdef CACHE_ARB_ROUNDROBIN_EN
    logic last_grant_q, last_grant_d;  // 0 = I$ granted last, 1 = D$
    assign tie_to_d = ~last_grant_q;
`else
    assign tie_to_d = 1'b1;
`endif

    assign i_req     = ICacheBusRW[1];
    assign d_req     = |DCacheBusRW;
    assign last_beat = (beat_q == LOGBWPL'(BEATSPERLINE - 1));

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        ICacheBusAck = 1'b0;
        DCacheBusAck = 1'b0;
        IBeatCount   = '0;
        DBeatCount   = '0;
        IGrant       = 1'b0;
        DGrant       = 1'b0;
        BusRW        = 2'b00;
        BusAdr       = '0;
        case (state_q)
            StIdle: begin
                beat_d = '0;
                if (i_req && d_req) begin
                    state_d = tie_to_d ? StDBus : StIBus;
                end else if (d_req) begin
                    state_d = StDBus;
                end else if (i_req) begin
                    state_d = StIBus;
                end
            end
            StIBus: begin
                IGrant     = 1'b1;
                BusRW      = {ICacheBusRW[1], 1'b0};
                BusAdr     = ICacheBusAdr;
                IBeatCount = beat_q;
                if (!i_req) begin
                    // Abort: drop the burst without an ack.
                    state_d = StIdle;
                    beat_d  = '0;
                end else if (BeatDone) begin
                    if (last_beat) begin
                        ICacheBusAck = 1'b1;
                        beat_d       = '0;
                        state_d      = StIdle;
                    end else begin
                        beat_d = beat_q + LOGBWPL'(1);
                    end
                end
            end
            StDBus: begin
                DGrant     = 1'b1;
                BusRW      = DCacheBusRW;
                BusAdr     = DCacheBusAdr;
                DBeatCount = beat_q;
                if (!d_req) begin
                    state_d = StIdle;
                    beat_d  = '0;
                end else if (BeatDone) begin
                    if (last_beat) begin
                        DCacheBusAck = 1'b1;
                        beat_d       = '0;
                        state_d      = StIdle;
                    end else begin
                        beat_d = beat_q + LOGBWPL'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

`ifdef CACHE_ARB_ROUNDROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && state_d == StDBus) begin
            last_grant_d = 1'b1;
        end else if (state_q == StIdle && state_d == StIBus) begin
            last_grant_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

`ifdef CACHE_ARB_ROUNDROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: cycle model plus directed literal checks.
module tb_cache_bus_arbiter;

    localparam int PA  = 34;
    localparam int LB  = 3;
    localparam int BPL = 8;
`ifdef CACHE_ARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    i_rw, d_rw;
    logic [PA-1:0] i_adr, d_adr;
    logic          beat_done;
    logic          i_ack, d_ack, i_grant, d_grant;
    logic [LB-1:0] i_beat, d_beat;
    logic [1:0]    bus_rw;
    logic [PA-1:0] bus_adr;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    cache_bus_arbiter #(.PA_BITS(PA), .LOGBWPL(LB), .BEATSPERLINE(BPL)) dut (
        .clk          (clk),
        .reset        (reset),
        .ICacheBusRW  (i_rw),
        .ICacheBusAdr (i_adr),
        .DCacheBusRW  (d_rw),
        .DCacheBusAdr (d_adr),
        .ICacheBusAck (i_ack),
        .DCacheBusAck (d_ack),
        .IBeatCount   (i_beat),
        .DBeatCount   (d_beat),
        .IGrant       (i_grant),
        .DGrant       (d_grant),
        .BusRW        (bus_rw),
        .BusAdr       (bus_adr),
        .BeatDone     (beat_done)
    );

    always #5 clk = ~clk;

    // Model: owner 0 = nobody, 1 = I$, 2 = D$; beats = completed beats in the burst.
    int            m_owner = 0;
    int            m_beats = 0;
    bit            m_last  = 1'b0;
    logic [1:0]    m_rw    = 2'b00;
    logic [PA-1:0] m_adr   = '0;

    function automatic int arbitrate(input bit ia, input bit da, input bit last);
        if (ia && da) return (RR && last) ? 1 : 2;
        if (da) return 2;
        if (ia) return 1;
        return 0;
    endfunction

    function automatic bit owner_active();
        if (m_owner == 1) return i_rw[1];
        if (m_owner == 2) return |d_rw;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_owner <= 0;
            m_beats <= 0;
            m_last  <= 1'b0;
        end else if (m_owner == 0) begin
            m_owner <= arbitrate(i_rw[1], |d_rw, m_last);
            if (arbitrate(i_rw[1], |d_rw, m_last) == 2) begin
                m_last <= 1'b1;
                m_rw   <= d_rw;
                m_adr  <= d_adr;
            end else if (arbitrate(i_rw[1], |d_rw, m_last) == 1) begin
                m_last <= 1'b0;
                m_rw   <= i_rw;
                m_adr  <= i_adr;
            end
        end else if (!owner_active()) begin
            m_owner <= 0;
            m_beats <= 0;
        end else if (beat_done) begin
            if (m_beats + 1 == BPL) begin
                m_owner <= 0;
                m_beats <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    function automatic logic [45:0] exp_outs();
        logic ig, dg, ia, da;
        logic [LB-1:0] ib, db;
        logic [1:0] rw;
        logic [PA-1:0] adr;
        bit fin;
        ig = 0; dg = 0; ia = 0; da = 0; ib = '0; db = '0; rw = 2'b00; adr = '0;
        fin = beat_done && owner_active() && (m_beats == BPL - 1);
        if (m_owner == 1) begin
            ig = 1; ib = LB'(m_beats); rw = {i_rw[1], 1'b0}; adr = i_adr; ia = fin;
        end else if (m_owner == 2) begin
            dg = 1; db = LB'(m_beats); rw = d_rw; adr = d_adr; da = fin;
        end
        return {ig, dg, ia, da, ib, db, rw, adr};
    endfunction

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            logic [45:0] exp_v, act_v;
            exp_v = exp_outs();
            act_v = {i_grant, d_grant, i_ack, d_ack, i_beat, d_beat, bus_rw, bus_adr};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
            end
            n_tests++;
            if ((i_grant && d_grant) || (i_ack && d_ack)) begin
                n_fail++;
                $display("FAIL exclusivity @%0t: grants %b%b acks %b%b required not both",
                         $time, i_grant, d_grant, i_ack, d_ack);
            end
            if (m_owner != 0 && owner_active()) begin
                n_tests++;
                if ((m_owner == 1 && (i_rw !== m_rw || i_adr !== m_adr)) ||
                    (m_owner == 2 && (d_rw !== m_rw || d_adr !== m_adr))) begin
                    n_fail++;
                    $display("FAIL request_stable @%0t: requester changed while granted", $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive beat_done for n cycles; start is the beat index expected on the first one.
    task automatic burst(input bit is_d, input int n, input int start);
        for (int b = 0; b < n; b++) begin
            beat_done = 1'b1;
            @(negedge clk);
            chk("beat_count", is_d ? 64'(d_beat) : 64'(i_beat), 64'(start + b));
            chk("own_ack", is_d ? 64'(d_ack) : 64'(i_ack), 64'(start + b == BPL - 1));
            chk("other_ack", is_d ? 64'(i_ack) : 64'(d_ack), 64'(0));
            cyc();
        end
        beat_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_rw = 2'b00; d_rw = 2'b00; i_adr = '0; d_adr = '0; beat_done = 1'b0;
        cyc();
        cmp_en = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_igrant", 64'(i_grant), 64'(0));
        chk("reset_dgrant", 64'(d_grant), 64'(0));
        chk("reset_busrw", 64'(bus_rw), 64'(0));
        chk("reset_busadr", 64'(bus_adr), 64'(0));
        cyc();

        // Single D$ fetch burst.
        d_rw = 2'b10; d_adr = 34'h0_8000_1000;
        @(negedge clk); chk("arb_cycle_dgrant", 64'(d_grant), 64'(0));
        cyc();
        @(negedge clk);
        chk("d_fetch_grant", 64'(d_grant), 64'(1));
        chk("d_fetch_busrw", 64'(bus_rw), 64'(2'b10));
        chk("d_fetch_busadr", 64'(bus_adr), 64'h8000_1000);
        cyc();
        burst(1'b1, 8, 0);
        d_rw = 2'b00;
        @(negedge clk);
        chk("d_done_idle", 64'(d_grant), 64'(0));
        chk("d_done_beat", 64'(d_beat), 64'(0));
        cyc();

        // I$ writeback bit alone is not a request.
        i_rw = 2'b01;
        @(negedge clk); cyc();
        @(negedge clk); chk("i_wb_ignored", 64'(i_grant), 64'(0));
        cyc();
        i_rw = 2'b00;

        // Contention from reset: D$ first, then I$, then tie-break mode decides.
        do_reset();
        i_rw = 2'b10; i_adr = 34'h1000; d_rw = 2'b01; d_adr = 34'h2000;
        @(negedge clk); cyc();
        @(negedge clk);
        chk("tie1_dgrant", 64'(d_grant), 64'(1));
        chk("tie1_busrw", 64'(bus_rw), 64'(2'b01));
        cyc();
        burst(1'b1, 8, 0);
        d_rw = 2'b00;
        @(negedge clk); chk("tie1_idle_gap", 64'(i_grant), 64'(0));
        cyc();
        @(negedge clk);
        chk("i_after_d", 64'(i_grant), 64'(1));
        chk("i_busadr", 64'(bus_adr), 64'h1000);
        cyc();
        burst(1'b0, 8, 0);
        d_rw = 2'b10;
        @(negedge clk); cyc();
        @(negedge clk); chk("tie2_dgrant", 64'(d_grant), 64'(1));
        cyc();
        burst(1'b1, 8, 0);
        @(negedge clk); cyc();
        @(negedge clk);
        chk("tie3_igrant", 64'(i_grant), 64'(RR));
        chk("tie3_dgrant", 64'(d_grant), 64'(!RR));
        cyc();
        burst(!RR, 8, 0);
        i_rw = 2'b00; d_rw = 2'b00;
        @(negedge clk); cyc();

        // Stalled D$ burst.
        d_rw = 2'b10; d_adr = 34'h3000;
        @(negedge clk); cyc();
        @(negedge clk); chk("stall_grant", 64'(d_grant), 64'(1));
        cyc();
        burst(1'b1, 3, 0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_hold", 64'(d_beat), 64'(3));
            chk("stall_noack", 64'(d_ack), 64'(0));
            cyc();
        end
        burst(1'b1, 5, 3);
        d_rw = 2'b00;
        @(negedge clk); chk("stall_idle", 64'(d_grant), 64'(0));
        cyc();

        // Reset in the middle of an I$ burst.
        i_rw = 2'b10; i_adr = 34'h4000;
        @(negedge clk); cyc();
        @(negedge clk); chk("rst_igrant", 64'(i_grant), 64'(1));
        cyc();
        burst(1'b0, 4, 0);
        reset = 1'b1; beat_done = 1'b1;
        @(negedge clk); cyc();
        reset = 1'b0; beat_done = 1'b0;
        @(negedge clk);
        chk("rst_mid_igrant", 64'(i_grant), 64'(0));
        chk("rst_mid_ibeat", 64'(i_beat), 64'(0));
        chk("rst_mid_iack", 64'(i_ack), 64'(0));
        cyc();
        @(negedge clk); chk("rst_regrant", 64'(i_grant), 64'(1));
        cyc();
        burst(1'b0, 8, 0);
        i_rw = 2'b00;
        @(negedge clk); cyc();

        // D$ aborts at beat 2 with an I$ request pending.
        d_rw = 2'b10; d_adr = 34'h5000;
        @(negedge clk); cyc();
        @(negedge clk); chk("abort_dgrant", 64'(d_grant), 64'(1));
        cyc();
        i_rw = 2'b10; i_adr = 34'h6000;
        burst(1'b1, 2, 0);
        d_rw = 2'b00;
        @(negedge clk);
        chk("abort_noack", 64'(d_ack), 64'(0));
        cyc();
        @(negedge clk);
        chk("abort_idle_d", 64'(d_grant), 64'(0));
        chk("abort_idle_i", 64'(i_grant), 64'(0));
        chk("abort_dbeat", 64'(d_beat), 64'(0));
        cyc();
        @(negedge clk);
        chk("abort_then_i", 64'(i_grant), 64'(1));
        chk("abort_i_busadr", 64'(bus_adr), 64'h6000);
        cyc();
        burst(1'b0, 8, 0);
        i_rw = 2'b00;
        @(negedge clk); cyc();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one line-burst bus port between the I$ and the D$ bus interfaces.
- Each cache presents a 2-bit RW request ([1] line fetch, [0] writeback) and a line address. The arbiter grants one requester at a time and holds the grant for the whole burst.
- It counts beats, returns the per-cache BeatCount, and pulses the per-cache bus ack on the final beat.
- It sits between the two cache FSMs and the AHB bus-interface FSM.

Parameters:
- PA_BITS, 34, physical address width.
- LOGBWPL, 3, beat counter width (log2 of beats per line).
- BEATSPERLINE, 8, beats per line burst; must equal 2**LOGBWPL.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ICacheBusRW  in  2  I$ request; only [1] is legal, [0] is ignored
- ICacheBusAdr  in  PA_BITS  I$ line address
- DCacheBusRW  in  2  D$ request; 10 fetch, 01 writeback
- DCacheBusAdr  in  PA_BITS  D$ line address
- ICacheBusAck  out  1  I$ burst complete
- DCacheBusAck  out  1  D$ burst complete
- IBeatCount  out  LOGBWPL  current beat for I$ (0 when not granted)
- DBeatCount  out  LOGBWPL  current beat for D$ (0 when not granted)
- IGrant  out  1  I$ owns bus
- DGrant  out  1  D$ owns bus
- BusRW  out  2  request to bus FSM
- BusAdr  out  PA_BITS  line address to bus FSM
- BeatDone  in  1  bus completed one beat this cycle

Behaviour:
- States: IDLE, IBUS, DBUS (registered). A 1-bit LastGrant register records the most recent grant (0 = I, 1 = D).
- Reset values:
  - state IDLE
  - LastGrant = 0, so D wins the first tie
  - beat counter 0
  - BusRW = 00, grants 0, acks 0, BusAdr = 0
- A request is active when its RW is nonzero. For the I$, only ICacheBusRW[1] counts.
- IDLE transitions:
  - No request: stay IDLE.
  - Only I active: go to IBUS.
  - Only D active: go to DBUS.
  - Both active: grant the one not equal to LastGrant, and update LastGrant at the same edge.
- Arbitration costs exactly one IDLE cycle. Outputs in IDLE: BusRW = 00, BusAdr = 0.
- In IBUS / DBUS:
  - Grant output high.
  - BusRW and BusAdr combinationally follow the granted requester's live RW and Adr.
  - The granted BeatCount equals the counter; the other BeatCount is 0.
- Beat counter:
  - Increments on BeatDone while granted.
  - On BeatDone with counter == BEATSPERLINE-1: assert the granted Ack combinationally that cycle, clear the counter to 0, and return to IDLE at the next edge.
- No back-to-back grant: a D$ writeback followed by a fetch re-arbitrates. Under contention the I$ may win between them.
- Requester changing RW or Adr while granted is illegal. It is not checked in RTL; the bench asserts on it.
- Requester dropping RW while granted (abort): at the next edge go to IDLE with the counter cleared and no ack.
- BeatDone while IDLE is ignored.
- Reset mid-burst: at the next edge return to IDLE, counter 0, LastGrant 0, no ack.
- Acks are never high simultaneously. At most one grant is high at any time.

Optional Feature:
- Macro: CACHE_ARB_ROUNDROBIN_EN.
- Defined: tie-break is round-robin via LastGrant, as described above.
- Undefined: fixed priority, D$ always wins ties. LastGrant is removed, with no other change in timing.

Test Plan:
- After reset, DCacheBusRW=10, Adr=0x80001000 -> DGrant=1 next cycle; BusRW=10, BusAdr=0x80001000; 8 BeatDone pulses give DBeatCount 0..7; DCacheBusAck high on beat 7 only; IDLE next cycle.
- ICacheBusRW=10 and DCacheBusRW=01 raised in the same cycle after reset -> D granted first; then I granted after one IDLE cycle. With both re-raised afterward, D is granted next (round-robin).
- Same scenario with CACHE_ARB_ROUNDROBIN_EN undefined and both re-raised -> D granted both times.
- D$ granted, BeatDone stalled low for 5 cycles mid-burst -> BeatCount holds its value and no ack until 8 beats have completed.
- Reset asserted at beat 4 of an I$ burst -> next cycle state IDLE, IGrant=0, IBeatCount=0, no ICacheBusAck; a fresh request then completes a full 8-beat burst.
- D$ drops DCacheBusRW at beat 2 -> IDLE next cycle, no ack; a pending I$ request is granted the following cycle.
